fam_edge_router: RTL and testbench

Parametrised edge-distribution front end for the FAM array. It accepts NUMIN independent edge streams with valid/ready handshakes and buffers each stream in a per-port FIFO. It decodes each edge's destination into a target FAM and a local address, then drives the flat per-FAM lane buses that feed a NUMFAM-wide FAM array. It adds the three things the current array wiring lacks: backpressure, per-FAM stall, and a flush/drain handshake for double-buffer swaps.

---
 rtl/fam_pkg.sv | 30 +++
 rtl/fam_edge_fifo.sv | 54 +++++
 rtl/fam_edge_router.sv | 158 +++++++++++++++
 tb/tb_fam_edge_router.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fam_pkg.sv
// Shared types and helpers for the FAM edge router: FSM states, edge record,
// FAM index width and lane numbering.
package fam_pkg;

    localparam int FAM_ADDRW_DEF = 16;
    localparam int FAM_WL_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fam_state_t;

    typedef struct packed {
        logic [FAM_ADDRW_DEF-1:0] src;
        logic [FAM_ADDRW_DEF-1:0] dst;
        logic [FAM_WL_DEF-1:0]    value;
    } fam_edge_t;

    function automatic int famw(input int numfam);
        return $clog2(numfam);
    endfunction

    // Flat lane number of port i on FAM f.
    function automatic int lane_idx(input int f, input int i, input int numin);
        return f * numin + i;
    endfunction

endpackage

// File: rtl/fam_edge_fifo.sv
// Per-port synchronous FIFO with occupancy count. Pushes into a full FIFO
// are dropped and pops from an empty FIFO are ignored.
module fam_edge_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

    // Storage is not reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fam_edge_router.sv
// Edge distribution front end: per-port FIFOs, FAM decode, per-FAM stall and
// flush/drain handshake. Define FAM_EDGE_STATS_EN to build per-FAM edge counters.
module fam_edge_router
    import fam_pkg::*;
#(
    parameter int ADDRW  = 16,
    parameter int WL     = 32,
    parameter int NUMIN  = 4,
    parameter int NUMFAM = 8,
    parameter int DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           flush_req,
    output logic                           flush_done,
    input  logic [ADDRW*NUMIN-1:0]         in_src,
    input  logic [ADDRW*NUMIN-1:0]         in_dst,
    input  logic [WL*NUMIN-1:0]            in_value,
    input  logic [NUMIN-1:0]               in_valid,
    output logic [NUMIN-1:0]               in_ready,
    input  logic [NUMFAM-1:0]              fam_stall,
    output logic [ADDRW*NUMIN*NUMFAM-1:0]  fam_src,
    output logic [ADDRW*NUMIN*NUMFAM-1:0]  fam_dst,
    output logic [WL*NUMIN*NUMFAM-1:0]     fam_value,
    output logic [NUMIN*NUMFAM-1:0]        fam_valid,
    output logic                           busy,
    output logic [32*NUMFAM-1:0]           edge_count
);
    localparam int FAMW = famw(NUMFAM);
    localparam int DW   = 2*ADDRW + WL + FAMW;
    localparam int CW   = $clog2(DEPTH) + 1;

    fam_state_t       r_state;
    fam_state_t       w_state_nxt;
    logic [NUMIN-1:0] w_vld;
    logic [NUMIN-1:0] w_empty_v;
    logic             w_all_empty;

    for (genvar i = 0; i < NUMIN; i++) begin : g_port
        logic [DW-1:0]    w_wdata;
        logic [DW-1:0]    w_rdata;
        logic [CW-1:0]    w_count;
        logic             w_empty;
        logic             w_push;
        logic             w_pop;
        logic [FAMW-1:0]  w_head_fam;
        logic             r_vld;
        logic [FAMW-1:0]  r_fam;
        logic [ADDRW-1:0] r_src;
        logic [ADDRW-1:0] r_dst;
        logic [WL-1:0]    r_val;

        // FIFO entry: {src, local dst, value, target FAM}
        assign w_wdata = {in_src[ADDRW*i +: ADDRW],
                          in_dst[ADDRW*i +: ADDRW] >> FAMW,
                          in_value[WL*i +: WL],
                          in_dst[ADDRW*i +: FAMW]};

        assign in_ready[i]  = (r_state == ST_RUN) && (w_count < CW'(DEPTH));
        assign w_push       = in_valid[i] && in_ready[i];
        assign w_head_fam   = w_rdata[FAMW-1:0];
        assign w_pop        = !w_empty && !fam_stall[w_head_fam];
        assign w_vld[i]     = r_vld;
        assign w_empty_v[i] = w_empty;

        fam_edge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push),
            .i_data  (w_wdata),
            .i_pop   (w_pop),
            .o_data  (w_rdata),
            .o_count (w_count),
            .o_empty (w_empty)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_fam <= '0;
                r_src <= '0;
                r_dst <= '0;
                r_val <= '0;
            end else begin
                r_vld <= w_pop;
                if (w_pop) begin
                    r_fam <= w_head_fam;
                    {r_src, r_dst, r_val} <= w_rdata[DW-1:FAMW];
                end
            end
        end

        // Data is broadcast to every lane of this port; only the target lane strobes.
        for (genvar f = 0; f < NUMFAM; f++) begin : g_lane
            localparam int K = lane_idx(f, i, NUMIN);
            assign fam_valid[K]                = r_vld && (r_fam == FAMW'(f));
            assign fam_src[ADDRW*K +: ADDRW]   = r_src;
            assign fam_dst[ADDRW*K +: ADDRW]   = r_dst;
            assign fam_value[WL*K +: WL]       = r_val;
        end
    end

    assign w_all_empty = &w_empty_v;
    assign busy        = !w_all_empty || (|w_vld);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        flush_done  = 1'b0;
        case (r_state)
            ST_IDLE:  if (ena) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush_req)
                    w_state_nxt = ST_DRAIN;
                else if (!ena)
                    w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: if (w_all_empty && !(|w_vld)) w_state_nxt = ST_DONE;
            ST_DONE: begin
                flush_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef FAM_EDGE_STATS_EN
    for (genvar f = 0; f < NUMFAM; f++) begin : g_stat
        logic [31:0] r_cnt;
        logic [31:0] w_inc;

        always_comb begin
            w_inc = '0;
            for (int i = 0; i < NUMIN; i++)
                w_inc = w_inc + 32'(fam_valid[lane_idx(f, i, NUMIN)]);
        end

        always_ff @(posedge clk) begin
            if (rst)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + w_inc;
        end

        assign edge_count[32*f +: 32] = r_cnt;
    end
`else
    assign edge_count = '0;
`endif

endmodule

// File: tb/tb_fam_edge_router.sv
// Bench for fam_edge_router: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_fam_edge_router;
    import fam_pkg::*;

    localparam int ADDRW  = 16;
    localparam int WL     = 32;
    localparam int NUMIN  = 4;
    localparam int NUMFAM = 8;
    localparam int DEPTH  = 8;
    localparam int NL     = NUMIN * NUMFAM;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     ena = 1'b0;
    logic                     flush_req = 1'b0;
    logic                     flush_done;
    logic [ADDRW*NUMIN-1:0]   in_src = '0;
    logic [ADDRW*NUMIN-1:0]   in_dst = '0;
    logic [WL*NUMIN-1:0]      in_value = '0;
    logic [NUMIN-1:0]         in_valid = '0;
    logic [NUMIN-1:0]         in_ready;
    logic [NUMFAM-1:0]        fam_stall = '0;
    logic [ADDRW*NL-1:0]      fam_src;
    logic [ADDRW*NL-1:0]      fam_dst;
    logic [WL*NL-1:0]         fam_value;
    logic [NL-1:0]            fam_valid;
    logic                     busy;
    logic [32*NUMFAM-1:0]     edge_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fam_edge_router #(.ADDRW(ADDRW), .WL(WL), .NUMIN(NUMIN), .NUMFAM(NUMFAM), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .in_src     (in_src),
        .in_dst     (in_dst),
        .in_value   (in_value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fam_stall  (fam_stall),
        .fam_src    (fam_src),
        .fam_dst    (fam_dst),
        .fam_value  (fam_value),
        .fam_valid  (fam_valid),
        .busy       (busy),
        .edge_count (edge_count)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        fam_edge_t  e;
        logic [2:0] fam;
    } mrec_t;

    mrec_t            mq [NUMIN][$];
    mrec_t            mout [NUMIN];
    logic [NUMIN-1:0] mvld = '0;
    fam_state_t       mst = ST_IDLE;
    logic [31:0]      mcnt [NUMFAM];
    bit               mok = 1'b0;
    int               dlv [NL];

    logic [NUMIN-1:0] m_rdy;
    logic [NUMIN-1:0] m_nv;
    logic [NL-1:0]    m_evld;
    bit               m_busy;
    bit               m_drained;
    mrec_t            m_rec;
    int               m_k;

    always @(negedge clk) begin
        for (int i = 0; i < NUMIN; i++)
            m_rdy[i] = (mst == ST_RUN) && (mq[i].size() < DEPTH);
        if (mok) begin
            m_evld = '0;
            m_busy = (mvld != 0);
            for (int i = 0; i < NUMIN; i++) begin
                if (mvld[i]) m_evld[int'(mout[i].fam) * NUMIN + i] = 1'b1;
                if (mq[i].size() != 0) m_busy = 1'b1;
            end
            check("in_ready", in_ready, m_rdy);
            check("fam_valid", fam_valid, m_evld);
            check("busy", busy, m_busy);
            check("flush_done", flush_done, mst == ST_DONE);
            for (int i = 0; i < NUMIN; i++) begin
                if (mvld[i]) begin
                    m_k = int'(mout[i].fam) * NUMIN + i;
                    check("lane_src", fam_src[ADDRW*m_k +: ADDRW], mout[i].e.src);
                    check("lane_dst", fam_dst[ADDRW*m_k +: ADDRW], mout[i].e.dst);
                    check("lane_value", fam_value[WL*m_k +: WL], mout[i].e.value);
                end
            end
`ifdef FAM_EDGE_STATS_EN
            for (int f = 0; f < NUMFAM; f++)
                check("edge_count", edge_count[32*f +: 32], mcnt[f]);
`else
            check("edge_count_tied", edge_count, '0);
`endif
        end
        for (int k = 0; k < NL; k++)
            if (fam_valid[k] === 1'b1) dlv[k]++;

        // advance the model to what the next rising edge must produce
        if (rst) begin
            for (int i = 0; i < NUMIN; i++) mq[i].delete();
            mvld = '0;
            mst  = ST_IDLE;
            for (int f = 0; f < NUMFAM; f++) mcnt[f] = '0;
            mok  = 1'b1;
        end else begin
            m_drained = (mvld == 0);
            for (int i = 0; i < NUMIN; i++) begin
                if (mq[i].size() != 0) m_drained = 1'b0;
                if (mvld[i]) mcnt[mout[i].fam] = mcnt[mout[i].fam] + 32'd1;
            end
            for (int i = 0; i < NUMIN; i++) begin
                m_nv[i] = 1'b0;
                if (mq[i].size() != 0 && !fam_stall[mq[i][0].fam]) begin
                    mout[i] = mq[i].pop_front();
                    m_nv[i] = 1'b1;
                end
                if (in_valid[i] && m_rdy[i]) begin
                    m_rec.e.src   = in_src[ADDRW*i +: ADDRW];
                    m_rec.e.dst   = 16'(in_dst[ADDRW*i +: ADDRW] / NUMFAM);
                    m_rec.e.value = in_value[WL*i +: WL];
                    m_rec.fam     = 3'(in_dst[ADDRW*i +: ADDRW] % NUMFAM);
                    mq[i].push_back(m_rec);
                end
            end
            mvld = m_nv;
            case (mst)
                ST_IDLE:  if (ena) mst = ST_RUN;
                ST_RUN:   if (flush_req) mst = ST_DRAIN; else if (!ena) mst = ST_IDLE;
                ST_DRAIN: if (m_drained) mst = ST_DONE;
                default:  mst = ST_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] src,
                         input logic [15:0] dst, input logic [31:0] val);
        in_valid[i]                 = v;
        in_src[ADDRW*i +: ADDRW]    = src;
        in_dst[ADDRW*i +: ADDRW]    = dst;
        in_value[WL*i +: WL]        = val;
    endtask

    function automatic int sum_dlv();
        int s = 0;
        for (int k = 0; k < NL; k++) s += dlv[k];
        return s;
    endfunction

    initial begin
        int acc, bad, base, dc;
        bit prev_done;
        logic [31:0] cnt_before;
        logic [NL-1:0] one_hot;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, '0);
        check("rst_fam_valid", fam_valid, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_edge_count", edge_count, '0);
        check("rst_fam_dst", fam_dst, '0);

        // single edge, dst 0x13 -> FAM 3, local 2, lane 12
        ena = 1'b1;
        tick();
        check("t1_ready", in_ready, 4'hF);
        drive(0, 1'b1, 16'h1234, 16'h0013, 32'hDEADBEEF);
        tick();
        in_valid = '0;
        check("t1_not_early", fam_valid, '0);
        tick();
        one_hot = '0;
        one_hot[12] = 1'b1;
        check("t1_lane_valid", fam_valid, one_hot);
        check("t1_lane_dst", fam_dst[ADDRW*12 +: ADDRW], 16'h0002);
        check("t1_lane_value", fam_value[WL*12 +: WL], 32'hDEADBEEF);
        tick();
        check("t1_once", fam_valid, '0);
        check("t1_dlv_count", dlv[12], 1);

        // stalled FAM 5 fills port 1, then drains in order
        fam_stall = 8'h20;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 1'b1, 16'(16'h100 + acc), 16'(5 + 8 * (acc + 1)), 32'hA000 + 32'(acc));
            if (in_ready[1]) acc++;
            tick();
        end
        check("t2_accepted", acc, 8);
        check("t2_ready_low", in_ready[1], 1'b0);
        in_valid = '0;
        tick();
        fam_stall = '0;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("t2_lane21_valid", fam_valid[21], 1'b1);
            check("t2_order_dst", fam_dst[ADDRW*21 +: ADDRW], 16'(k + 1));
            tick();
        end
        check("t2_lane21_done", fam_valid[21], 1'b0);

        // four ports streaming to distinct FAMs for 100 cycles
        base = sum_dlv();
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < NUMIN; i++)
                drive(i, 1'b1, 16'($urandom), 16'(i + 8 * $urandom_range(0, 8000)), $urandom);
            if (in_ready != 4'hF) bad++;
            tick();
        end
        in_valid = '0;
        repeat (3) tick();
        check("t3_ready_const", bad, 0);
        check("t3_deliveries", sum_dlv() - base, 400);

        // flush with three edges queued behind a stall
        fam_stall = 8'h40;
        for (int k = 0; k < 3; k++) begin
            drive(2, 1'b1, 16'(k), 16'(6 + 8 * (k + 1)), 32'(k));
            tick();
        end
        in_valid = '0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("t4_ready_drop", in_ready, '0);
        base = dlv[26];
        fam_stall = '0;
        dc = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (prev_done) check("t4_idle_after_done", in_ready, '0);
            prev_done = flush_done;
            if (flush_done) dc++;
            tick();
        end
        check("t4_done_pulses", dc, 1);
        check("t4_delivered", dlv[26] - base, 3);

        // reset with five edges buffered
        fam_stall = 8'h80;
        for (int k = 0; k < 5; k++) begin
            drive(3, 1'b1, 16'(k), 16'(7 + 8 * k), 32'(k));
            tick();
        end
        in_valid = '0;
        check("t5_busy_before", busy, 1'b1);
        base = dlv[31];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_fam_valid", fam_valid, '0);
        check("t5_busy", busy, 1'b0);
        check("t5_in_ready", in_ready, '0);
        fam_stall = '0;
        repeat (10) tick();
        check("t5_no_stale", dlv[31] - base, 0);

        // all four ports hit FAM 2 in the same cycle
        for (int i = 0; i < NUMIN; i++)
            drive(i, 1'b1, 16'(i), 16'(2 + 8 * (i + 1)), 32'(i));
        tick();
        in_valid = '0;
        tick();
        check("t6_lanes", fam_valid[11:8], 4'hF);
        cnt_before = edge_count[64 +: 32];
        tick();
`ifdef FAM_EDGE_STATS_EN
        check("t6_cnt_before", cnt_before, 32'd0);
        check("t6_cnt_step", edge_count[64 +: 32] - cnt_before, 32'd4);
`else
        check("t6_cnt_zero", edge_count, '0);
        check("t6_cnt_before_zero", cnt_before, 32'd0);
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            ena       = ($urandom_range(0, 99) < 95);
            flush_req = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 999) < 3);
            for (int f = 0; f < NUMFAM; f++)
                fam_stall[f] = ($urandom_range(0, 99) < 30);
            for (int i = 0; i < NUMIN; i++)
                drive(i, $urandom_range(0, 99) < 60, 16'($urandom), 16'($urandom), $urandom);
            tick();
        end
        rst = 1'b0;
        flush_req = 1'b0;
        fam_stall = '0;
        in_valid = '0;
        repeat (20) tick();
        check("final_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
